// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 word sequencer: register addresses,
// FSM state encoding and the power-up init word table.
package max7219_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  // Number of words in the power-up sequence.
  localparam int INIT_LEN = 5;

  typedef enum logic [2:0] {
    ST_WAIT_READY = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_SENT  = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_FINISH     = 3'd4,
    ST_IDLE       = 3'd5
  } state_t;

  // Init word for position index of the power-up sequence.
  function automatic logic [15:0] init_word(input logic [2:0] index,
                                            input logic [3:0] intensity,
                                            input logic [7:0] scan);
    case (index)
      3'd0:    init_word = {4'h0, REG_DECODE,    8'hFF};
      3'd1:    init_word = {4'h0, REG_INTENSITY, 4'h0, intensity};
      3'd2:    init_word = {4'h0, REG_SCANLIMIT, scan};
      3'd3:    init_word = {4'h0, REG_SHUTDOWN,  8'h01};
      default: init_word = {4'h0, REG_TEST,      8'h00};
    endcase
  endfunction

endpackage

// File: rtl/max7219_frame_sequencer.sv
// Produces the MAX7219 init sequence after reset and one digit frame per
// update request, handing each 16-bit word to the SPI master and owning cs.
module max7219_frame_sequencer
  import max7219_pkg::*;
#(
  parameter logic [3:0] INTENSITY  = 4'h8,
  parameter int         NUM_DIGITS = 8,
  parameter int         CS_GAP     = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic        update,
  input  logic [31:0] digits,
  input  logic        spi_send,
  input  logic        spi_ready,
  output logic        cs,
  output logic [15:0] word_out,
  output logic        busy,
  output logic        init_done
);

  state_t      state, state_next;
  logic [2:0]  idx;
  logic        seq_init;
  logic [3:0]  gap_cnt;
  logic        pending;
  logic [31:0] frame;
  logic        last_word;
  logic [15:0] word_next;

  // Digit word for position k of the latched frame.
  function automatic logic [15:0] digit_word(input logic [31:0] f, input logic [2:0] k);
    digit_word = {4'h0, 4'({1'b0, k}) + REG_DIGIT0, 4'h0, f[{k, 2'b00} +: 4]};
  endfunction

  assign last_word = seq_init ? (idx == 3'(INIT_LEN - 1)) : (idx == 3'(NUM_DIGITS - 1));
  assign word_next = seq_init ? init_word(idx, INTENSITY, 8'(NUM_DIGITS - 1))
                              : digit_word(frame, idx);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (res) state <= ST_WAIT_READY;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      ST_WAIT_READY: if (spi_ready && !spi_send && gap_cnt == 4'd0) state_next = ST_LOAD;
      ST_LOAD:       state_next = ST_WAIT_SENT;
      ST_WAIT_SENT:  if (spi_send) state_next = ST_RELEASE;
      ST_RELEASE:    state_next = last_word ? ST_FINISH : ST_WAIT_READY;
      ST_FINISH:     state_next = ST_IDLE;
      ST_IDLE:       if (pending || update) state_next = ST_WAIT_READY;
      default:       state_next = ST_WAIT_READY;
    endcase
  end

  // Datapath: word/cs outputs, index, gap counter, frame latch and flags.
  always_ff @(posedge clk) begin
    if (res) begin
      cs        <= 1'b1;
      word_out  <= 16'h0000;
      busy      <= 1'b0;
      init_done <= 1'b0;
      pending   <= 1'b0;
      idx       <= 3'd0;
      seq_init  <= 1'b1;
      gap_cnt   <= 4'd0;
      frame     <= 32'h0;
    end else begin
      // Requests arriving while a sequence is running collapse into one.
      if (update && state != ST_IDLE) pending <= 1'b1;
      case (state)
        ST_WAIT_READY: begin
          if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
          if (state_next == ST_LOAD) busy <= 1'b1;
        end
        ST_LOAD: begin
          word_out <= word_next;
          cs       <= 1'b0;
        end
        ST_RELEASE: begin
          cs      <= 1'b1;
          gap_cnt <= 4'(CS_GAP);
          if (!last_word) idx <= idx + 3'd1;
        end
        ST_FINISH: begin
          if (seq_init) init_done <= 1'b1;
          busy <= 1'b0;
        end
        ST_IDLE: begin
          if (pending || update) begin
            frame    <= digits;
            pending  <= 1'b0;
            busy     <= 1'b1;
            idx      <= 3'd0;
            seq_init <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/max7219_frame_sequencer.md
Name: max7219_frame_sequencer

Overview:
- Upstream feeder for the 16-bit SPI master. It produces every word the clock sends to the MAX7219 8-digit 7-segment driver and owns chip-select.
- After reset it sends the fixed init sequence once.
- On each update request it sends one frame of NUM_DIGITS digit words.
- It handshakes each word through the SPI master's cs_in / report_send / report_ready interface.

Parameters:
- INTENSITY, 4'h8, value written to the intensity register (0x0A).
- NUM_DIGITS, 8, digits per frame (1..8). Scan-limit register is written with NUM_DIGITS-1.
- CS_GAP, 2, minimum cycles cs is held high between words (1..15).

Ports:
- clk  in  1  system clock
- res  in  1  synchronous reset, active-high
- update  in  1  one-cycle request to send a new frame
- digits  in  32  BCD/code-B nibbles; digits[4k+3:4k] is digit k, written to register k+1
- spi_send  in  1  SPI master report_send (word shifted out)
- spi_ready  in  1  SPI master report_ready (master idle)
- cs  out  1  to SPI master cs_in; low = transfer in progress
- word_out  out  16  to SPI master word_in: {4'h0, addr[3:0], data[7:0]}
- busy  out  1  high from the start of any word until the end of the sequence or frame
- init_done  out  1  high once the init sequence has completed; cleared only by res

Behaviour:
- Reset (res=1 at clk edge): cs=1, word_out=0, busy=0, init_done=0, pending=0, state=WAIT_READY, next sequence = INIT. Reset mid-transfer aborts immediately. Raising cs returns the SPI master to idle.
- Init sequence, in order:
  - 0x09FF: decode mode, code B on all digits
  - {0x0A, 4'h0, INTENSITY}: intensity
  - {0x0B, NUM_DIGITS-1}: scan limit
  - 0x0C01: normal operation
  - 0x0F00: display test off
- Frame: words {0x0(k+1), 4'h0, digits nibble k} for k = 0..NUM_DIGITS-1, ascending.
  - digits is latched into a frame register when the frame starts.
  - Later changes to digits do not affect the frame in flight.
- FSM states:
  - WAIT_READY: cs=1. Advance when spi_ready=1 and spi_send=0 and the gap counter has expired.
  - LOAD: word_out <= current word (held stable until the next LOAD). cs <= 0.
  - WAIT_SENT: cs=0. Stay until spi_send=1.
  - RELEASE: cs <= 1. Load the gap counter with CS_GAP. If this was the last word of the sequence, go to FINISH; else increment the index and go to WAIT_READY.
  - FINISH: set init_done=1 (if the sequence was INIT) and busy <= 0, then go to IDLE.
  - IDLE: cs=1. If pending or update, latch digits, clear pending, busy <= 1, go to WAIT_READY with index 0.
- busy rises in the cycle LOAD is first entered for a sequence and stays high through FINISH.
- Updates during init or during a frame set pending (multiple requests collapse into one). The next frame starts straight from IDLE after FINISH. An update on the same cycle FINISH completes is captured in pending and is not lost.
- spi_send is sampled only in WAIT_SENT. It stays high for one cycle after cs rises, so WAIT_READY must also require spi_send=0.
- Gap counter: 4-bit down-counter, decremented every cycle in WAIT_READY. Expired at 0.
- Minimum time per word: LOAD→WAIT_SENT, plus SPI time of 16×4 clk, plus RELEASE, plus max(CS_GAP, SPI master return to ready).
- NUM_DIGITS < 8: unused digit registers are never written.

Decomposition:
- Shared package max7219_pkg holds:
  - register address constants: REG_DIGIT0=4'h1, REG_DECODE=4'h9, REG_INTENSITY=4'hA, REG_SCANLIMIT=4'hB, REG_SHUTDOWN=4'hC, REG_TEST=4'hF
  - state encoding localparams
  - a function init_word(index, intensity, scan) returning the 16-bit init word
- No sub-module. Init ROM and digit mux are combinational functions inside the block.

Test Plan:
- Reset release with a behavioural SPI master model attached → exactly 5 cs-low windows carrying 0x09FF, 0x0A08, 0x0B07, 0x0C01, 0x0F00 in order. init_done rises after the 5th cs rises. No digit words are sent.
- After init, pulse update with digits=32'h8765_4321 → 8 words 0x0101, 0x0202 … 0x0808. busy high throughout. busy falls after the 8th word.
- update pulsed during init word 2 with digits=32'hFFFF_FFA0 → init completes, then one frame 0x0100, 0x020A, 0x030F … 0x080F.
- Three update pulses during one frame, digits changed mid-frame → the current frame is unaffected. Exactly one further frame follows, carrying the digits value latched at its start.
- Delay spi_send by 100 cycles → cs stays low, word_out stable. Check that cs stays high for ≥ CS_GAP cycles and that the next LOAD waits for spi_ready=1 and spi_send=0.
- Assert res during word 4 of a frame → next cycle cs=1, busy=0, init_done=0. The full init sequence is then resent and pending is cleared.
